// File: rtl/pcileech_tlp_tx_arbiter.sv
// Packet-granular round-robin arbiter for the 64-bit PCIe TX stream, with cfg-TX slot servicing.
// Optional build macro PCILEECH_TLP_ARB_PRIO0_EN gives source 0 strict priority at packet start.
module pcileech_tlp_tx_arbiter #(
    parameter int unsigned N_SRC   = 4,
    parameter int unsigned USER_W  = 22,
    parameter int unsigned MIN_BUF = 2,
    parameter int unsigned GID_W   = $clog2(N_SRC)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_SRC*64-1:0]     s_data,
    input  logic [N_SRC*8-1:0]      s_keep,
    input  logic [N_SRC-1:0]        s_last,
    input  logic [N_SRC*USER_W-1:0] s_user,
    input  logic [N_SRC-1:0]        s_valid,
    output logic [N_SRC-1:0]        s_ready,
    output logic [63:0]             m_data,
    output logic [7:0]              m_keep,
    output logic                    m_last,
    output logic [USER_W-1:0]       m_user,
    output logic                    m_valid,
    input  logic                    m_ready,
    input  logic [5:0]              tx_buf_av,
    input  logic                    tx_cfg_req,
    output logic                    tx_cfg_gnt,
    output logic [GID_W-1:0]        grant_id,
    output logic                    busy,
    output logic [15:0]             pkt_cnt
);

    typedef enum logic [1:0] {StIdle, StCfg, StBusy} state_e;

    state_e           state_q, state_d;
    logic [GID_W-1:0] grant_id_q, grant_id_d;
    logic [15:0]      pkt_cnt_q, pkt_cnt_d;
    logic [GID_W-1:0] winner;
    logic             win_found;
    int unsigned      idx;
    logic             pkt_done;

    // Search starts one past the last winner so every source gets a turn.
    always_comb begin
        winner    = grant_id_q;
        win_found = 1'b0;
        idx       = 0;
`ifdef PCILEECH_TLP_ARB_PRIO0_EN
        if (s_valid[0]) begin
            winner    = '0;
            win_found = 1'b1;
        end
`endif
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            idx = (32'(grant_id_q) + k) % N_SRC;
`ifdef PCILEECH_TLP_ARB_PRIO0_EN
            if (!win_found && idx != 0 && s_valid[GID_W'(idx)]) begin
`else
            if (!win_found && s_valid[GID_W'(idx)]) begin
`endif
                winner    = GID_W'(idx);
                win_found = 1'b1;
            end
        end
    end

    assign m_data   = s_data[64*grant_id_q +: 64];
    assign m_keep   = s_keep[8*grant_id_q +: 8];
    assign m_last   = s_last[grant_id_q];
    assign m_user   = s_user[USER_W*grant_id_q +: USER_W];
    assign pkt_done = m_valid & m_ready & m_last;
    assign grant_id = grant_id_q;
    assign pkt_cnt  = pkt_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            grant_id_q <= GID_W'(N_SRC - 1);
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    // Credits are checked only at packet start; an in-flight packet is never aborted.
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        pkt_cnt_d  = pkt_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (tx_cfg_req) begin
                    state_d = StCfg;
                end else if (win_found && tx_buf_av >= 6'(MIN_BUF)) begin
                    grant_id_d = winner;
                    state_d    = StBusy;
                end
            end
            StCfg: begin
                if (!tx_cfg_req) state_d = StIdle;
            end
            StBusy: begin
                if (pkt_done) begin
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        tx_cfg_gnt = 1'b0;
        m_valid    = 1'b0;
        s_ready    = '0;
        unique case (state_q)
            StCfg: tx_cfg_gnt = 1'b1;
            StBusy: begin
                busy                = 1'b1;
                m_valid             = s_valid[grant_id_q];
                s_ready[grant_id_q] = m_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pcileech_tlp_tx_arbiter.sv
// Bench for pcileech_tlp_tx_arbiter: arbitration vector table, cfg/reset sequences, and
// randomized traffic checked against a queue-free behavioural model of the packet arbiter.
module tb_pcileech_tlp_tx_arbiter;
    localparam int N  = 4;
    localparam int UW = 22;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*64-1:0] s_data;
    logic [N*8-1:0]  s_keep;
    logic [N-1:0]    s_last;
    logic [N*UW-1:0] s_user;
    logic [N-1:0]    s_valid;
    logic [N-1:0]    s_ready;
    logic [63:0]     m_data;
    logic [7:0]      m_keep;
    logic            m_last;
    logic [UW-1:0]   m_user;
    logic            m_valid;
    logic            m_ready;
    logic [5:0]      tx_buf_av;
    logic            tx_cfg_req;
    logic            tx_cfg_gnt;
    logic [1:0]      grant_id;
    logic            busy;
    logic [15:0]     pkt_cnt;

    pcileech_tlp_tx_arbiter #(.N_SRC(N), .USER_W(UW), .MIN_BUF(2), .GID_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
        .s_user(s_user), .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data),
        .m_keep(m_keep), .m_last(m_last), .m_user(m_user), .m_valid(m_valid),
        .m_ready(m_ready), .tx_buf_av(tx_buf_av), .tx_cfg_req(tx_cfg_req),
        .tx_cfg_gnt(tx_cfg_gnt), .grant_id(grant_id), .busy(busy), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] mask;
        logic [5:0] av;
        bit         exp_busy;
        int         exp_grant;
    } vec_t;
    vec_t tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mkdata(input int i, input int sq, input int b);
        return {8'(i), 8'(sq), 16'(b), 32'hC0DE_0000 + 32'(i)};
    endfunction
    function automatic logic [7:0] mkkeep(input int i, input int b);
        return 8'(8'hF0 | (i + b));
    endfunction
    function automatic logic [UW-1:0] mkuser(input int i, input int b);
        return UW'(i * 16 + b + 22'h100);
    endfunction

    task automatic set_src(input int i, input logic v, input logic l, input int sq, input int b);
        s_valid[i]          = v;
        s_last[i]           = l;
        s_data[64*i +: 64]  = mkdata(i, sq, b);
        s_keep[8*i +: 8]    = mkkeep(i, b);
        s_user[UW*i +: UW]  = mkuser(i, b);
    endtask

    // Winner = valid source closest after the last grant, going upward modulo N.
    function automatic int pick(input logic [N-1:0] mask, input int rr);
        int best = -1;
        int bd   = N + 1;
`ifdef PCILEECH_TLP_ARB_PRIO0_EN
        if (mask[0]) return 0;
`endif
        for (int i = 0; i < N; i++) begin
`ifdef PCILEECH_TLP_ARB_PRIO0_EN
            if (i == 0) continue;
`endif
            if (mask[i] && ((i - rr - 1 + N) % N) < bd) begin
                bd   = (i - rr - 1 + N) % N;
                best = i;
            end
        end
        return best;
    endfunction

    int exp_cnt;
    int owner, rr, mcnt;
    int len[N], beat[N], seq[N];
    logic [N-1:0] vld, acc;
    logic exp_mv;
    logic [N-1:0] exp_sr;

    initial begin
        rst_n = 1'b0; s_data = '0; s_keep = '0; s_last = '0; s_user = '0; s_valid = '0;
        m_ready = 1'b0; tx_buf_av = '0; tx_cfg_req = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_cfg_gnt", tx_cfg_gnt, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_grant", grant_id, 3);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        exp_cnt = 0;

`ifdef PCILEECH_TLP_ARB_PRIO0_EN
        tbl = '{'{4'b1111, 6'd10, 1, 0}, '{4'b1111, 6'd10, 1, 0}, '{4'b0101, 6'd10, 1, 0},
                '{4'b0101, 6'd10, 1, 0}, '{4'b1000, 6'd1, 0, 0}, '{4'b1000, 6'd2, 1, 3},
                '{4'b0000, 6'd10, 0, 3}, '{4'b0010, 6'd10, 1, 1}, '{4'b0011, 6'd10, 1, 0},
                '{4'b0011, 6'd10, 1, 0}, '{4'b1100, 6'd10, 1, 2}, '{4'b1011, 6'd10, 1, 0}};
`else
        tbl = '{'{4'b1111, 6'd10, 1, 0}, '{4'b1111, 6'd10, 1, 1}, '{4'b0101, 6'd10, 1, 2},
                '{4'b0101, 6'd10, 1, 0}, '{4'b1000, 6'd1, 0, 0}, '{4'b1000, 6'd2, 1, 3},
                '{4'b0000, 6'd10, 0, 3}, '{4'b0010, 6'd10, 1, 1}, '{4'b0011, 6'd10, 1, 0},
                '{4'b0011, 6'd10, 1, 1}, '{4'b1100, 6'd10, 1, 2}, '{4'b1011, 6'd10, 1, 3}};
`endif
        // Single-beat packets: decision edge, then one handshake cycle back to IDLE
        for (int e = 0; e < 12; e++) begin
            for (int i = 0; i < N; i++) set_src(i, tbl[e].mask[i], 1'b1, e, 0);
            tx_buf_av = tbl[e].av;
            m_ready   = 1'b1;
            @(posedge clk); #1;
            check("tbl_busy", busy, 64'(tbl[e].exp_busy));
            check("tbl_grant", grant_id, 64'(tbl[e].exp_grant));
            if (tbl[e].exp_busy) begin
                check("tbl_m_valid", m_valid, 1);
                check("tbl_m_data", m_data, mkdata(tbl[e].exp_grant, e, 0));
                check("tbl_m_keep", m_keep, 64'(mkkeep(tbl[e].exp_grant, 0)));
                check("tbl_m_user", m_user, 64'(mkuser(tbl[e].exp_grant, 0)));
                check("tbl_s_ready", s_ready, 64'(1 << tbl[e].exp_grant));
                @(posedge clk); #1;
                exp_cnt++;
                check("tbl_done_busy", busy, 0);
                check("tbl_pkt_cnt", pkt_cnt, 64'(exp_cnt));
            end
            s_valid = '0;
        end

        // Cfg request arriving mid-packet waits for the packet's last beat
        set_src(0, 1'b1, 1'b0, 50, 0);
        m_ready = 1'b0; tx_buf_av = 6'd10;
        @(posedge clk); #1;
        check("cfg_busy0", busy, 1);
        check("cfg_grant0", grant_id, 0);
        check("cfg_sready_stall", s_ready, 0);
        tx_cfg_req = 1'b1;
        @(posedge clk); #1;
        check("cfg_busy_hold", busy, 1);
        check("cfg_gnt_blocked", tx_cfg_gnt, 0);
        m_ready = 1'b1; set_src(0, 1'b1, 1'b1, 50, 1);
        #1;
        check("cfg_sready0", s_ready, 4'b0001);
        @(posedge clk); #1;
        exp_cnt++;
        check("cfg_after_last_busy", busy, 0);
        check("cfg_after_last_gnt", tx_cfg_gnt, 0);
        check("cfg_after_last_cnt", pkt_cnt, 64'(exp_cnt));
        set_src(0, 1'b1, 1'b1, 51, 0);
        @(posedge clk); #1;
        check("cfg_gnt_on", tx_cfg_gnt, 1);
        check("cfg_m_valid_off", m_valid, 0);
        check("cfg_sready_off", s_ready, 0);
        @(posedge clk); #1;
        check("cfg_gnt_held", tx_cfg_gnt, 1);
        tx_cfg_req = 1'b0;
        @(posedge clk); #1;
        check("cfg_gnt_off", tx_cfg_gnt, 0);
        check("cfg_idle_busy", busy, 0);
        @(posedge clk); #1;
        check("cfg_resume_busy", busy, 1);
        check("cfg_resume_grant", grant_id, 0);
        check("cfg_resume_data", m_data, mkdata(0, 51, 0));
        @(posedge clk); #1;
        exp_cnt++;
        check("cfg_resume_cnt", pkt_cnt, 64'(exp_cnt));
        s_valid = '0;

        // Reset mid-packet
        set_src(2, 1'b1, 1'b0, 60, 0);
        m_ready = 1'b0;
        @(posedge clk); #1;
        check("rstmid_busy", busy, 1);
        check("rstmid_grant", grant_id, 2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rstmid_busy_clr", busy, 0);
        check("rstmid_grant_rst", grant_id, 3);
        check("rstmid_cnt_rst", pkt_cnt, 0);
        check("rstmid_m_valid", m_valid, 0);
        rst_n = 1'b1;
        s_valid = '0;

        // Randomized traffic against the behavioural model
        owner = -1; rr = N - 1; mcnt = 0;
        for (int i = 0; i < N; i++) begin
            vld[i] = 1'b0; beat[i] = 0; seq[i] = 0; len[i] = $urandom_range(1, 4);
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!vld[i]) vld[i] = ($urandom_range(0, 2) != 0);
                set_src(i, vld[i], beat[i] == len[i] - 1, seq[i], beat[i]);
            end
            m_ready   = ($urandom_range(0, 3) != 0);
            tx_buf_av = 6'($urandom_range(0, 8));
            if (!tx_cfg_req) tx_cfg_req = ($urandom_range(0, 39) == 0);
            else             tx_cfg_req = ($urandom_range(0, 3) != 0);
            #3;
            exp_mv = (owner >= 0) && vld[owner];
            exp_sr = (owner >= 0 && m_ready) ? N'(1 << owner) : '0;
            check("rnd_busy", busy, 64'(owner >= 0));
            check("rnd_m_valid", m_valid, 64'(exp_mv));
            check("rnd_s_ready", s_ready, 64'(exp_sr));
            check("rnd_cfg_gnt", tx_cfg_gnt, 64'(owner == -2));
            check("rnd_grant", grant_id, 64'(rr));
            check("rnd_pkt_cnt", pkt_cnt, 64'(mcnt));
            if (exp_mv) begin
                check("rnd_m_data", m_data, mkdata(owner, seq[owner], beat[owner]));
                check("rnd_m_last", m_last, 64'(beat[owner] == len[owner] - 1));
            end
            acc = s_valid & s_ready;
            if (owner == -1) begin
                if (tx_cfg_req) owner = -2;
                else if (vld != '0 && tx_buf_av >= 6'd2) begin
                    owner = pick(vld, rr);
                    rr    = owner;
                end
            end else if (owner == -2) begin
                if (!tx_cfg_req) owner = -1;
            end else if (vld[owner] && m_ready && beat[owner] == len[owner] - 1) begin
                mcnt  = (mcnt + 1) % 65536;
                owner = -1;
            end
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    if (beat[i] == len[i] - 1) begin
                        beat[i] = 0; seq[i]++; len[i] = $urandom_range(1, 4);
                    end else begin
                        beat[i]++;
                    end
                    vld[i] = 1'($urandom_range(0, 1));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
